// File: rtl/modbus_crc_pkg.sv
// CRC-16/MODBUS shared definitions.
// Polynomial/preset constants, engine state type, single-bit CRC step.
package modbus_crc_pkg;

    localparam logic [15:0] CRC_POLY = 16'hA001;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } crc_state_t;

    // Advance a reflected CRC register by one message bit.
    function automatic logic [15:0] crc16_bit(
        input logic [15:0] crc,
        input logic        b,
        input logic [15:0] poly = CRC_POLY
    );
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? poly : 16'h0000);
    endfunction

endpackage

// File: rtl/modbus_crc_step.sv
// Combinational CRC-16 advance over N message bits.
// Bits are folded LSB first, matching the wire order.
module modbus_crc_step
    import modbus_crc_pkg::*;
#(
    parameter int          N    = 1,
    parameter logic [15:0] POLY = CRC_POLY
) (
    input  logic [15:0]  crc_in,
    input  logic [N-1:0] bits,
    output logic [15:0]  crc_out
);

    // Chain N single-bit steps; bit 0 is consumed first.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < N; i++) begin
            crc_out = crc16_bit(crc_out, bits[i], POLY);
        end
    end

endmodule

// File: rtl/modbus_crc_engine.sv
// CRC-16/MODBUS engine: generate or check over a buffered frame.
// Folds BITS_PER_CYCLE bits per clock; registered result strobe.
module modbus_crc_engine
    import modbus_crc_pkg::*;
#(
    parameter int          MAX_BYTES      = 8,
    parameter int          BITS_PER_CYCLE = 1,
    parameter logic [15:0] POLY           = CRC_POLY,
    parameter logic [15:0] INIT           = CRC_INIT,
    localparam int         LEN_W          = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   start_in,
    input  logic [8*MAX_BYTES-1:0] data_in,
    input  logic [LEN_W-1:0]       len_in,
    input  logic                   check_mode_in,
    output logic                   busy,
    output logic                   crc_done,
    output logic [15:0]            crc_out,
    output logic                   crc_ok,
    output logic                   len_err
);

    localparam logic [2:0]       BIT_STEP = 3'(BITS_PER_CYCLE);
    localparam logic [2:0]       LAST_BIT = 3'(8 - BITS_PER_CYCLE);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);

    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8)) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    if (MAX_BYTES < 1 || MAX_BYTES > 256) begin : g_bad_max
        $error("MAX_BYTES must be in 1..256");
    end

    crc_state_t r_state;
    crc_state_t w_next;

    logic [8*MAX_BYTES-1:0] r_data;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_idx;
    logic [2:0]             r_bit;
    logic                   r_mode;
    logic                   r_len_err;
    logic [15:0]            r_crc;

    logic                   r_busy;
    logic                   r_done;
    logic [15:0]            r_crc_out;
    logic                   r_ok;
    logic                   r_lerr;

    logic                   w_start;
    logic                   w_over;
    logic [LEN_W-1:0]       w_eff_len;
    logic                   w_last_bit;
    logic                   w_last_byte;
    logic [15:0]            w_crc_next;

    assign w_start     = (r_state == IDLE) && !r_busy && start_in;
    assign w_over      = (len_in > MAX_LEN);
    assign w_eff_len   = w_over ? MAX_LEN : len_in;
    assign w_last_bit  = (r_bit == LAST_BIT);
    assign w_last_byte = (r_idx == r_len - LEN_W'(1));

    // The shift register always presents the next unread bits at its LSBs.
    modbus_crc_step #(
        .N    (BITS_PER_CYCLE),
        .POLY (POLY)
    ) u_step (
        .crc_in  (r_crc),
        .bits    (r_data[BITS_PER_CYCLE-1:0]),
        .crc_out (w_crc_next)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; empty frames skip straight to the result.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_next = (w_eff_len == '0) ? DONE : CALC;
            end
            CALC: begin
                if (w_last_bit && w_last_byte) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Job capture and CRC folding datapath.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_data    <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_bit     <= '0;
            r_mode    <= 1'b0;
            r_len_err <= 1'b0;
            r_crc     <= '0;
        end else begin
            if (r_state == LOAD) begin
                r_data    <= data_in;
                r_mode    <= check_mode_in;
                r_len     <= w_eff_len;
                r_len_err <= w_over;
                r_crc     <= INIT;
                r_idx     <= '0;
                r_bit     <= '0;
            end else if (r_state == CALC) begin
                r_crc  <= w_crc_next;
                r_data <= r_data >> BITS_PER_CYCLE;
                if (w_last_bit) begin
                    r_bit <= '0;
                    r_idx <= r_idx + LEN_W'(1);
                end else begin
                    r_bit <= r_bit + BIT_STEP;
                end
            end
        end
    end

    // Result registers update only on DONE; strobe lasts one cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_done    <= 1'b0;
            r_crc_out <= '0;
            r_ok      <= 1'b0;
            r_lerr    <= 1'b0;
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_crc_out <= r_crc;
                r_ok      <= r_mode && (r_crc == 16'h0000);
                r_lerr    <= r_len_err;
            end
        end
    end

    // Busy spans acceptance through the strobe cycle, blocking restarts.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end else if (r_done) begin
            r_busy <= 1'b0;
        end
    end

    assign busy     = r_busy;
    assign crc_done = r_done;
    assign crc_out  = r_crc_out;
    assign crc_ok   = r_ok;
    assign len_err  = r_lerr;

endmodule
